// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory initiator.
//   op_e    : cmd_op encodings (LOAD, STORE, COPY, FILL)
//   state_e : sequencer states
//   MEM_DEPTH : number of bytes in the attached data memory
package data_mem_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_COPY  = 2'd2,
        OP_FILL  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STORE = 3'd2,
        S_CP_RD = 3'd3,
        S_CP_WR = 3'd4,
        S_FILL  = 3'd5,
        S_RESP  = 3'd6
    } state_e;

    localparam int MEM_DEPTH = 32;

endpackage

// File: rtl/data_mem_master.sv
// Initiator for the single-port 8-bit data memory. Accepts LOAD/STORE/COPY/FILL
// commands on a valid/ready handshake, sequences them onto the memory one byte
// per access, and returns one response per command.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_LOAD  | mem_address = addr, read data sampled at the end of the cycle
// S_STORE | single write cycle of data to addr
// S_CP_RD | read byte src+cnt into the copy buffer
// S_CP_WR | write the copy buffer to dst+cnt
// S_FILL  | write data to dst+cnt
// S_RESP  | rsp_valid held until rsp_ready
//
// Ports:
//   clk, reset                  : clock, async active-high reset
//   cmd_valid/cmd_ready         : command handshake
//   cmd_op/addr/src/len/data    : command fields, latched on acceptance
//   rsp_valid/rsp_ready/rsp_data: response handshake
//   busy                        : not idle
//   mem_address/write/wdata     : registered memory-side outputs
//   mem_rdata                   : combinational read data from the memory
module data_mem_master
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [7:0]        cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_e            state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [7:0]        data_q;
    logic [7:0]        buf_q;

    logic [LEN_W-1:0]  len_clamped;
    logic [LEN_W-1:0]  cnt_nxt;
    logic              last_byte;

    always_comb begin
        len_clamped = cmd_len;
        if (cmd_len > LEN_W'(MEM_DEPTH))
            len_clamped = LEN_W'(MEM_DEPTH);
    end

    assign cnt_nxt   = cnt + 1'b1;
    assign last_byte = (cnt_nxt == len_q);

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state != S_IDLE);

    // Memory-side outputs are set on the edge entering the access cycle so that
    // address, data and strobe are stable for the whole cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            len_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            data_q      <= '0;
            buf_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            mem_address <= '0;
            mem_write   <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        src_q  <= cmd_src;
                        dst_q  <= cmd_addr;
                        len_q  <= len_clamped;
                        data_q <= cmd_data;
                        cnt    <= '0;
                        case (cmd_op)
                            OP_LOAD: begin
                                mem_address <= cmd_addr;
                                state       <= S_LOAD;
                            end
                            OP_STORE: begin
                                mem_address <= cmd_addr;
                                mem_wdata   <= cmd_data;
                                mem_write   <= 1'b1;
                                state       <= S_STORE;
                            end
                            OP_COPY: begin
                                if (len_clamped == '0) begin
                                    rsp_data  <= 8'h00;
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end else begin
                                    mem_address <= cmd_src;
                                    state       <= S_CP_RD;
                                end
                            end
                            default: begin
                                if (len_clamped == '0) begin
                                    rsp_data  <= cmd_data;
                                    rsp_valid <= 1'b1;
                                    state     <= S_RESP;
                                end else begin
                                    mem_address <= cmd_addr;
                                    mem_wdata   <= cmd_data;
                                    mem_write   <= 1'b1;
                                    state       <= S_FILL;
                                end
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    rsp_data  <= mem_rdata;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_STORE: begin
                    mem_write <= 1'b0;
                    rsp_data  <= data_q;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_CP_RD: begin
                    // The buffer and the write data are loaded from the same sample.
                    buf_q       <= mem_rdata;
                    mem_wdata   <= mem_rdata;
                    mem_address <= dst_q + ADDR_W'(cnt);
                    mem_write   <= 1'b1;
                    state       <= S_CP_WR;
                end
                S_CP_WR: begin
                    mem_write <= 1'b0;
                    if (last_byte) begin
                        rsp_data  <= buf_q;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt         <= cnt_nxt;
                        mem_address <= src_q + ADDR_W'(cnt_nxt);
                        state       <= S_CP_RD;
                    end
                end
                S_FILL: begin
                    if (last_byte) begin
                        mem_write <= 1'b0;
                        rsp_data  <= data_q;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        cnt         <= cnt_nxt;
                        mem_address <= dst_q + ADDR_W'(cnt_nxt);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    mem_write <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
